// File: rtl/condlogic_pkg.sv
// Shared definitions for the multicycle conditional-execution unit:
// ARM condition-code encodings, NZCV bit positions and the context-select
// width helper. Optional build macro used elsewhere: CONDLOGIC_FLAGFWD_EN.
package condlogic_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Context-select width; a single context still needs a 1-bit select port.
  function automatic int ctx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/condlogic_mc_cond_eval.sv
// Combinational ARM condition evaluator: condition field + NZCV -> pass/fail.
// AL and the reserved NV encoding both evaluate true so the result is never X.
module cond_eval
  import condlogic_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  // Decode the condition field against the selected flags.
  always_comb begin
    cond_ex_o = 1'b1;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      COND_NV: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/condlogic_mc.sv
// Multicycle conditional-execution unit. One NZCV register per context;
// the condition is captured once at Decode (CondLatch) and held, and the flag
// update is staged then applied at ALU writeback (FlagCommit).
// Build macro CONDLOGIC_FLAGFWD_EN: when CondLatch and FlagCommit coincide on
// the pending context, the condition sees the post-commit flags.
module condlogic_mc
  import condlogic_pkg::*;
#(
  parameter int         NCTX        = 2,
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  localparam int        CTXW        = ctx_width(NCTX)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      Cond,
  input  logic [3:0]      ALUFlags,
  input  logic [1:0]      FlagW,
  input  logic            PCS,
  input  logic            NextPC,
  input  logic            RegW,
  input  logic            MemW,
  input  logic [CTXW-1:0] CtxSel,
  input  logic            CondLatch,
  input  logic            FlagCommit,
  input  logic            Flush,
  output logic            PCWrite,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            CondEx,
  output logic [3:0]      Flags,
  output logic            FlagPend
);

  logic [3:0]      flags_q [NCTX];
  logic [3:0]      flags_d [NCTX];
  logic            cond_ex_q, cond_ex_d;
  logic [1:0]      flagw_pend_q, flagw_pend_d;
  logic [CTXW-1:0] ctx_pend_q, ctx_pend_d;

  logic [CTXW-1:0] rd_ctx;
  logic [3:0]      eval_flags;
  logic            cond_ex_comb;

  // Out-of-range selects fall back to context 0 for both reads and capture.
  assign rd_ctx = (int'(CtxSel) < NCTX) ? CtxSel : '0;

  // Flags presented to the condition evaluator (optionally bypassing a commit).
  always_comb begin
    eval_flags = flags_q[rd_ctx];
`ifdef CONDLOGIC_FLAGFWD_EN
    if (FlagCommit && CondLatch && (rd_ctx == ctx_pend_q)) begin
      if (flagw_pend_q[1]) eval_flags[3:2] = ALUFlags[3:2];
      if (flagw_pend_q[0]) eval_flags[1:0] = ALUFlags[1:0];
    end
`endif
  end

  cond_eval u_cond_eval (
    .cond_i    (Cond),
    .flags_i   (eval_flags),
    .cond_ex_o (cond_ex_comb)
  );

  // Next state: Flush wins; otherwise commit the old pending update, then capture.
  always_comb begin
    flags_d      = flags_q;
    cond_ex_d    = cond_ex_q;
    flagw_pend_d = flagw_pend_q;
    ctx_pend_d   = ctx_pend_q;
    if (Flush) begin
      cond_ex_d    = 1'b0;
      flagw_pend_d = 2'b00;
    end else begin
      if (FlagCommit) begin
        for (int i = 0; i < NCTX; i++) begin
          if (int'(ctx_pend_q) == i) begin
            if (flagw_pend_q[1]) flags_d[i][3:2] = ALUFlags[3:2];
            if (flagw_pend_q[0]) flags_d[i][1:0] = ALUFlags[1:0];
          end
        end
        flagw_pend_d = 2'b00;
      end
      if (CondLatch) begin
        cond_ex_d    = cond_ex_comb;
        flagw_pend_d = FlagW & {2{cond_ex_comb}};
        ctx_pend_d   = rd_ctx;
      end
    end
  end

  // State registers; reset discards any pending update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCTX; i++) flags_q[i] <= RESET_FLAGS;
      cond_ex_q    <= 1'b0;
      flagw_pend_q <= 2'b00;
      ctx_pend_q   <= '0;
    end else begin
      flags_q      <= flags_d;
      cond_ex_q    <= cond_ex_d;
      flagw_pend_q <= flagw_pend_d;
      ctx_pend_q   <= ctx_pend_d;
    end
  end

  assign PCWrite  = NextPC | (PCS & cond_ex_q);
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  assign CondEx   = cond_ex_q;
  assign Flags    = flags_q[rd_ctx];
  assign FlagPend = |flagw_pend_q;

endmodule

// File: doc/condlogic_mc.md
Name: condlogic_mc

Overview:
- Parametrised multicycle conditional-execution unit for the ARM-subset multicycle processor; sits between the main FSM decoder and the datapath write enables.
- Keeps one NZCV flag register per hardware context (NCTX contexts).
- Evaluates the instruction condition once, in Decode, and holds the result for the rest of the instruction.
- Stages the flag update and commits it in the ALU writeback state, so flags never change mid-instruction.

Parameters:
- NCTX, 2, number of independent flag contexts (1..8); CTXW = max(1, $clog2(NCTX)) is a derived localparam.
- RESET_FLAGS, 4'b0000, NZCV value loaded into every context on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Cond  in  4  instruction condition field.
- ALUFlags  in  4  NZCV from ALU; bit3 N, bit2 Z, bit1 C, bit0 V.
- FlagW  in  2  bit1 enables the NZ update, bit0 enables the CV update.
- PCS  in  1  instruction writes PC (branch or Rd=R15).
- NextPC  in  1  FSM unconditional PC increment.
- RegW  in  1  FSM register-write request.
- MemW  in  1  FSM memory-write request.
- CtxSel  in  CTXW  active context.
- CondLatch  in  1  FSM Decode strobe; captures condition result and pending flag enables.
- FlagCommit  in  1  FSM ALUWB strobe; applies pending flag update.
- Flush  in  1  aborts the current instruction's pending state.
- PCWrite  out  1  NextPC | (PCS & CondExQ).
- RegWrite  out  1  RegW & CondExQ.
- MemWrite  out  1  MemW & CondExQ.
- CondEx  out  1  registered condition result (CondExQ).
- Flags  out  4  NZCV of context CtxSel.
- FlagPend  out  1  OR of pending flag enables.

Behaviour:
- Reset (async, immediate):
  - Every context flag register loads RESET_FLAGS.
  - CondExQ=0, FlagWPend=2'b00, CtxPend=0.
  - Hence RegWrite=0, MemWrite=0, FlagPend=0, and PCWrite=NextPC.
- Condition evaluation is combinational on Cond and Flags[CtxSel] and produces CondExComb:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) gives 1. 1111 is also treated as 1; the result is never X.
- CtxSel >= NCTX selects context 0, for reads and for capture.
- Rising edge with CondLatch=1:
  - CondExQ <= CondExComb.
  - FlagWPend <= FlagW & {2{CondExComb}}.
  - CtxPend <= CtxSel.
- Rising edge with FlagCommit=1:
  - If FlagWPend[1]: Flags[CtxPend][3:2] <= ALUFlags[3:2].
  - If FlagWPend[0]: Flags[CtxPend][1:0] <= ALUFlags[1:0].
  - FlagWPend <= 0 on the same edge.
  - FlagCommit with FlagWPend=0 is a no-op.
- CondLatch and FlagCommit on the same edge:
  - The commit uses the old FlagWPend/CtxPend.
  - The new capture uses pre-commit flags (unless FLAGFWD_EN) and overwrites FlagWPend.
- Flush=1 on an edge clears CondExQ and FlagWPend. Flush has priority over CondLatch and FlagCommit, and flags are untouched.
- Latency:
  - Condition to write enables: 1 cycle after CondLatch.
  - Flag update: visible on Flags the cycle after FlagCommit.
- CondExQ holds until the next CondLatch/Flush. Write enables stay valid through the MemWrite, ALUWB and MemWB states.
- Reset asserted mid-instruction discards any pending update.

Optional Feature:
- Macro CONDLOGIC_FLAGFWD_EN.
- Defined: when FlagCommit and CondLatch coincide and CtxSel==CtxPend, condition evaluation uses the post-commit flags (pending fields replaced by ALUFlags). This is a single-cycle bypass for back-to-back flag-setting then conditional instructions.
- Undefined: condition evaluation always uses stored flags. The FSM must insert one cycle between the two strobes.

Decomposition:
- condlogic_pkg holds:
  - condition-code localparams COND_EQ..COND_AL (0..14) and COND_NV (15).
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, cond_eval (Cond, Flags -> CondEx), instantiated once.
- The flag bank and the pending registers live in the top module.

Test Plan:
- Reset, then Cond=0000 (EQ), CondLatch -> CondEx=0, RegWrite=0 with RegW=1, Flags=0000, PCWrite=NextPC.
- FlagW=11, Cond=1110, CondLatch, then ALUFlags=0100 with FlagCommit -> Flags=0100 next cycle. Then Cond=0000, CondLatch, RegW=1 -> RegWrite=1.
- Ctx0 flags=0100, CtxSel=1, Cond=0000, CondLatch -> CondEx=0; Flags(ctx1)=0000 and ctx0 unchanged.
- FlagW=01, Cond=0001 (NE) with Z=1, CondLatch, ALUFlags=1111, FlagCommit -> no flag change, FlagPend=0. PCS=1, NextPC=0 -> PCWrite=0.
- FlagW=10 latched, then Flush before FlagCommit -> FlagPend=0, commit ignored, CondEx=0, MemWrite=0.
- Simultaneous FlagCommit (ALUFlags=0100, pend NZ) and CondLatch (Cond=EQ, same ctx):
  - CondEx=1 with CONDLOGIC_FLAGFWD_EN.
  - CondEx=0 without it.
